uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive buffer that sits directly downstream of the UART receiver. It captures each completed byte from the receiver's level-style valid/data outputs and queues it in a small synchronous FIFO. The CPU-side register logic drains it through a pop strobe. It also provides empty, full and count status, a sticky overrun flag, and a level interrupt that replaces the receiver's one-deep irq/ack scheme.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
IRQ_THRESHOLD, 1, irq asserts when occupancy >= this value; legal range 1..DEPTH

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_data  input  8  byte from the receiver; stable while rx_valid is high
rx_valid  input  1  receiver valid; level signal, rises once per completed byte, may stay high across bytes
rd_en  input  1  pop strobe from the CPU side, one entry per cycle asserted
clear  input  1  flush strobe; empties the FIFO and clears overrun
ien  input  1  interrupt enable
rd_data  output  8  head-of-queue byte (first-word-fall-through)
empty  output  1  occupancy == 0
full  output  1  occupancy == DEPTH
count  output  $clog2(DEPTH)+1  current occupancy
overrun  output  1  sticky: a byte arrived while full and was dropped
irq  output  1  registered level interrupt

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - rd_ptr, wr_ptr and count = 0; empty = 1; full = 0; overrun = 0; irq = 0.
  - rx_valid_q (the edge-detect history register) resets to 1, so a receiver valid already high out of reset is not taken as a new byte.
  - Storage array is not reset.
- Capture:
  - push = rx_valid & ~rx_valid_q; rx_valid_q <= rx_valid every cycle.
  - Only a rising edge queues a byte; rx_data is sampled in the edge cycle.
  - A valid that stays high queues exactly one byte.
- Write: on push and not full (after pop is accounted for):
  - mem[wr_ptr] <= rx_data; wr_ptr increments with wrap modulo DEPTH.
- Read: on rd_en and not empty:
  - rd_ptr increments with wrap.
  - rd_en while empty is ignored; no pointer movement, no error flag.
- rd_data:
  - Shows mem[rd_ptr] combinationally when not empty.
  - Forced to 8'h00 when empty.
  - Updates the cycle after a pop or after the first push into an empty FIFO.
- Occupancy and latency:
  - count: +1 on accepted push only, -1 on accepted pop only, unchanged on both.
  - empty and full are derived from the registered count (no combinational path from the inputs).
  - Latency from the rx_valid rising edge to empty = 0 is 1 cycle.
- Simultaneous events:
  - Push + pop when full: pop frees the slot and the push is accepted; count stays DEPTH; overrun not set.
  - Push + pop when empty: pop is ignored and the push is accepted; count = 1.
  - Push when full without pop: byte dropped; overrun <= 1; pointers and count unchanged.
- overrun: once set, stays set until clear or rst.
- clear:
  - Has priority over push and pop in the same cycle.
  - Pointers and count <= 0; overrun <= 0; a coincident push is discarded.
  - rx_valid_q still updates, so the same valid pulse is not captured later.
- irq:
  - irq <= ien & ((count_next >= IRQ_THRESHOLD) | overrun_next), registered one cycle after the causing event.
  - ien low forces irq to 0 on the next cycle.
  - There is no ack: the interrupt is cleared by draining below the threshold or by clear.
- Reset mid-operation: stored bytes are lost; the FIFO behaves as after power-up.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_W = 8
  - the default FIFO depth constant
  - a count-width helper function, shared with a future TX FIFO
- The generic storage and pointer logic belongs in one sub-module, sync_fifo (parameters WIDTH, DEPTH; push, pop, clear, full/empty/count).
- uart_rx_fifo wraps sync_fifo with the edge detect, overrun and irq logic.

Test Plan:
- Receiver valid rises once with rx_data = 8'hA5 and stays high 50 cycles -> count = 1 one cycle after the edge, rd_data = 8'hA5, no second entry; rd_en pulse -> empty = 1, rd_data = 8'h00.
- Push 16 bytes 8'h00..8'h0F, then a 17th byte 8'hFF -> full = 1, overrun = 1, count = 16; 16 pops return 8'h00..8'h0F in order; overrun stays 1 until clear.
- FIFO full with push and rd_en in the same cycle (byte 8'h3C) -> count stays 16, overrun = 0, and 8'h3C is returned last after 16 pops.
- ien = 1, IRQ_THRESHOLD = 4: push 3 bytes -> irq = 0; 4th byte -> irq = 1 one cycle later; one pop -> irq = 0; ien = 0 with overrun = 1 -> irq = 0.
- Push 5 bytes, assert clear in the same cycle as a 6th push -> count = 0, empty = 1, overrun = 0, 6th byte not stored; rd_en on the empty FIFO -> no change.
- rst asserted with 7 bytes stored and rx_valid high -> all outputs at reset values next cycle; keep rx_valid high after reset -> no capture until it falls and rises again.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and helpers for the RX (and future TX) buffers.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int FIFO_DEPTH_DEFAULT = 16;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head, flush and
// occupancy count. DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_next
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign push_ok = push & (~full | pop_ok);

  // Next-state pointers and occupancy; clear overrides any push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok && !clear && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata      = empty ? '0 : mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each rising edge of the receiver valid into
// a FIFO, tracks sticky overrun and drives a registered level interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH         = FIFO_DEPTH_DEFAULT,
  parameter int IRQ_THRESHOLD = 1,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_valid,
  input  logic                   rd_en,
  input  logic                   clear,
  input  logic                   ien,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [CW-1:0]          count,
  output logic                   overrun,
  output logic                   irq
);

  logic          rx_valid_q;
  logic          overrun_q, overrun_d;
  logic          irq_q, irq_d;
  logic          push;
  logic          drop;
  logic [CW-1:0] count_next;

  assign push = rx_valid & ~rx_valid_q;
  // A byte is lost only when full and no pop makes room this cycle.
  assign drop = push & full & ~rd_en;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (rd_en),
    .clear      (clear),
    .wdata      (rx_data),
    .rdata      (rd_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .count_next (count_next)
  );

  // Next overrun and interrupt levels, both computed from post-event state.
  always_comb begin
    overrun_d = clear ? 1'b0 : (overrun_q | drop);
    irq_d     = ien & ((count_next >= CW'(IRQ_THRESHOLD)) | overrun_d);
  end

  // Edge-detect history resets high so a valid already asserted is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b1;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
    end
  end

  assign overrun = overrun_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int TH    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic       clear = 1'b0;
  logic       ien = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, overrun, irq;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .IRQ_THRESHOLD(TH)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_en(rd_en), .clear(clear), .ien(ien), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .overrun(overrun), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue plus overrun/irq flags.
  logic [7:0] q[$];
  bit m_ovr = 0, m_irq = 0, m_rvq = 1, armed = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete(); m_ovr = 0; m_irq = 0; m_rvq = 1; armed = 1;
    end else begin
      bit pe;
      pe = rx_valid && !m_rvq;
      if (clear) begin
        q.delete(); m_ovr = 0;
      end else begin
        if (rd_en && q.size() > 0) void'(q.pop_front());
        if (pe) begin
          if (q.size() < DEPTH) q.push_back(rx_data);
          else m_ovr = 1;
        end
      end
      m_irq = ien && ((q.size() >= TH) || m_ovr);
      m_rvq = rx_valid;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("m_count",   32'(count),   32'(q.size()));
      chk("m_empty",   32'(empty),   32'(q.size() == 0));
      chk("m_full",    32'(full),    32'(q.size() == DEPTH));
      chk("m_overrun", 32'(overrun), 32'(m_ovr));
      chk("m_irq",     32'(irq),     32'(m_irq));
      chk("m_rd_data", 32'(rd_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic byte_in(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; tick();
    rx_valid = 1'b0; tick();
  endtask

  task automatic pop1();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
  endtask

  task automatic flush();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_irq",   32'(irq),   32'h0);
    rst = 1'b0; tick();

    // Long valid level queues exactly one byte.
    rx_data = 8'hA5; rx_valid = 1'b1; tick();
    chk("a5_count", 32'(count), 32'h1);
    chk("a5_data",  32'(rd_data), 32'hA5);
    repeat (50) tick();
    chk("a5_hold_count", 32'(count), 32'h1);
    rx_valid = 1'b0;
    pop1();
    chk("a5_empty", 32'(empty), 32'h1);
    chk("a5_zero",  32'(rd_data), 32'h0);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) byte_in(8'(i));
    byte_in(8'hFF);
    chk("ovf_full",    32'(full),    32'h1);
    chk("ovf_overrun", 32'(overrun), 32'h1);
    chk("ovf_count",   32'(count),   32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(rd_data), 32'(i));
      pop1();
    end
    chk("drain_empty",   32'(empty),   32'h1);
    chk("ovf_sticky",    32'(overrun), 32'h1);
    flush();
    chk("ovf_cleared",   32'(overrun), 32'h0);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) byte_in(8'(8'h10 + i));
    rx_data = 8'h3C; rx_valid = 1'b1; rd_en = 1'b1; tick();
    rd_en = 1'b0; rx_valid = 1'b0; tick();
    chk("pp_count",   32'(count),   32'd16);
    chk("pp_overrun", 32'(overrun), 32'h0);
    for (int i = 0; i < 15; i++) begin
      chk("pp_data", 32'(rd_data), 32'(8'h11 + i));
      pop1();
    end
    chk("pp_last", 32'(rd_data), 32'h3C);
    pop1();
    chk("pp_empty", 32'(empty), 32'h1);

    // Interrupt threshold, overrun-driven irq, and enable gating.
    ien = 1'b1;
    for (int i = 0; i < 3; i++) byte_in(8'(8'h40 + i));
    chk("irq_below", 32'(irq), 32'h0);
    byte_in(8'h43);
    chk("irq_at_th", 32'(irq), 32'h1);
    pop1();
    chk("irq_drain", 32'(irq), 32'h0);
    for (int i = 0; i < 14; i++) byte_in(8'(8'h50 + i));
    chk("irq_ovr_flag", 32'(overrun), 32'h1);
    chk("irq_ovr",      32'(irq),     32'h1);
    ien = 1'b0; tick();
    chk("irq_ien_off",  32'(irq),     32'h0);
    flush();

    // Clear wins over a coincident push; pop on empty is a no-op.
    for (int i = 0; i < 5; i++) byte_in(8'(8'h60 + i));
    rx_data = 8'h77; rx_valid = 1'b1; clear = 1'b1; tick();
    clear = 1'b0; tick(); rx_valid = 1'b0; tick();
    chk("clr_count",   32'(count),   32'h0);
    chk("clr_empty",   32'(empty),   32'h1);
    chk("clr_overrun", 32'(overrun), 32'h0);
    pop1();
    chk("clr_pop_count", 32'(count), 32'h0);
    chk("clr_pop_data",  32'(rd_data), 32'h0);

    // Reset mid-operation with valid held high.
    for (int i = 0; i < 7; i++) byte_in(8'(8'h80 + i));
    rx_data = 8'h99; rx_valid = 1'b1; rst = 1'b1; tick();
    chk("mrst_count", 32'(count), 32'h0);
    chk("mrst_empty", 32'(empty), 32'h1);
    chk("mrst_data",  32'(rd_data), 32'h0);
    rst = 1'b0;
    repeat (5) tick();
    chk("mrst_nocap", 32'(count), 32'h0);
    rx_valid = 1'b0; tick();
    rx_valid = 1'b1; tick();
    chk("mrst_cap_count", 32'(count), 32'h1);
    chk("mrst_cap_data",  32'(rd_data), 32'h99);
    rx_valid = 1'b0; tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
